// File: rtl/uart_rx_parity_check.sv
// UART receive-side deserialiser with parity check and a saturating parity-error counter.
// Bits arrive LSB-first as bit_valid strobes; results are presented for one cycle in DONE.
module uart_rx_parity_check #(
  parameter int Data_Width = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  clear_cnt,
  output logic [Data_Width-1:0] P_DATA,
  output logic                  data_done,
  output logic                  Par_Err,
  output logic                  busy,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(Data_Width + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(Data_Width - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [Data_Width-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [Data_Width-1:0] p_data_q, p_data_d;
  logic                  done_q, done_d;
  logic                  par_err_q, par_err_d;
  logic                  busy_q, busy_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic                  restart;
  logic                  exp_par;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      p_data_q  <= '0;
      done_q    <= 1'b0;
      par_err_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      p_data_q  <= p_data_d;
      done_q    <= done_d;
      par_err_q <= par_err_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    p_data_d  = p_data_q;
    done_d    = 1'b0;
    par_err_d = par_err_q;
    err_d     = err_q;
    restart   = 1'b0;
    exp_par   = par_typ_q ? ~par_q : par_q;

    case (state_q)
      IDLE: begin
        if (frame_start) restart = 1'b1;
      end
      DATA: begin
        if (frame_start) begin
          restart = 1'b1;
        end else if (bit_valid) begin
          shift_d = {sampled_bit, shift_q[Data_Width-1:1]};
          par_d   = par_q ^ sampled_bit;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = PARITY;
            end else begin
              state_d   = DONE;
              done_d    = 1'b1;
              p_data_d  = shift_d;
              par_err_d = 1'b0;
            end
          end
        end
      end
      PARITY: begin
        if (frame_start) begin
          restart = 1'b1;
        end else if (bit_valid) begin
          state_d   = DONE;
          done_d    = 1'b1;
          p_data_d  = shift_q;
          par_err_d = (sampled_bit != exp_par);
          if ((sampled_bit != exp_par) && (err_q != {ERR_CNT_W{1'b1}})) begin
            err_d = err_q + ERR_CNT_W'(1);
          end
        end
      end
      DONE: begin
        // A frame_start here chains straight into the next frame.
        if (frame_start) restart = 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // frame_start always wins over a coincident bit_valid, which is dropped.
    if (restart) begin
      state_d   = DATA;
      shift_d   = '0;
      cnt_d     = '0;
      par_d     = 1'b0;
      par_err_d = 1'b0;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
    end

    if (clear_cnt) err_d = '0;

    busy_d = (state_d != IDLE);
  end

  assign P_DATA    = p_data_q;
  assign data_done = done_q;
  assign Par_Err   = par_err_q;
  assign busy      = busy_q;
  assign err_count = err_q;
  assign dbg_state = state_q;

endmodule
